note_sequencer: RTL
===================

Name: note_sequencer

Overview:
- Programmable step sequencer that drives the frequency/waveform-select inputs of the tone generator (freq_ctrl, sw) plus a gate for the output stage.
- Holds a small pattern RAM of notes: frequency, one-hot waveform, duration in tempo ticks.
- Sequencer FSM steps through the pattern at a tick rate derived from the system clock, inserting a fixed silent gap between notes.
- Sits between the control/UI logic and frequency_control.

Parameters:
- depth_p, 8, pattern entries (power of 2, ≥2)
- tick_div_p, 12_000, clk cycles per tempo tick (≥1; 1 kHz tick at 12 MHz)
- gap_ticks_p, 1, silent ticks between notes (0 = no gap state)

Ports:
- clk_i  in  1  system clock
- reset_ni  in  1  asynchronous active-low reset
- wr_v_i  in  1  pattern write valid
- wr_ready_o  out  1  write accepted this cycle when wr_v_i & wr_ready_o
- wr_addr_i  in  $clog2(depth_p)  entry index
- wr_data_i  in  28  {dur[27:20] 8b, wave[19:16] 4b one-hot, freq[15:0] Hz}
- start_i  in  1  start-playback pulse
- stop_i  in  1  abort-playback pulse
- freq_o  out  16  to freq_ctrl_i of tone generator
- sw_o  out  4  waveform select to sw_i
- gate_o  out  1  note sounding
- busy_o  out  1  FSM not IDLE
- step_o  out  $clog2(depth_p)  current entry index
- done_o  out  1  one-cycle pulse at natural end of pattern

Behaviour:
- Reset (reset_ni=0, async): state IDLE; freq_o=0, sw_o=0, gate_o=0, busy_o=0, step_o=0, done_o=0, tick/dur counters 0. Pattern RAM is not reset and retains contents across reset.
- All outputs are registered.
- Writes:
  - wr_ready_o = (state==IDLE).
  - Write takes effect on the handshake edge.
  - wr_v_i while busy is ignored; RAM is unchanged.
- States: IDLE, FETCH, NOTE, GAP.
- IDLE:
  - freq_o=0, sw_o=0, gate_o=0.
  - start_i & !stop_i → FETCH with step=0.
- FETCH (1 cycle):
  - Reads RAM[step]; gate_o=0.
  - dur==0 is the end marker: → IDLE, done_o=1 the following cycle.
  - Otherwise → NOTE and load freq_o, sw_o, duration counter.
  - gate_o=1 if freq≠0, else 0 (rest entry: freq_o=0, silent for full duration).
- NOTE:
  - Lasts exactly dur*tick_div_p cycles; tick divider is cleared on entry.
  - Then → GAP, or → FETCH if gap_ticks_p==0.
- GAP:
  - gate_o=0; freq_o/sw_o hold their last values.
  - Lasts gap_ticks_p*tick_div_p cycles, then → FETCH with step+1.
- End of pattern: after the NOTE/GAP of entry depth_p-1, → IDLE with done_o pulse. There is no index wrap beyond depth_p-1.
- stop_i:
  - In any non-IDLE state → IDLE next cycle; gate_o, freq_o, sw_o cleared; step_o=0.
  - No done_o pulse.
  - stop_i and start_i together: stop wins.
- start_i while busy is ignored.
- busy_o = (state!=IDLE).
- step_o = index of the entry currently fetched or playing.
- Counters:
  - Tick divider width $clog2(tick_div_p).
  - 8-bit duration counter counts down to 0; no overflow is possible.

Optional Feature:
- Macro NOTE_SEQ_LOOP_EN.
- Defined: at end of pattern (end marker or entry depth_p-1 finished), FSM goes to FETCH with step=0 instead of IDLE. done_o still pulses one cycle per wrap; busy_o stays 1; only stop_i or reset exits.
- Not defined: single-shot behaviour as above.

Test Plan:
- Bench parameters: tick_div_p=4, gap_ticks_p=1, depth_p=8. Cycle 0 = start_i accepted.
1. Reset asserted mid-NOTE (async, between edges) → all outputs 0 immediately; after release, busy_o=0, wr_ready_o=1.
2. Program {440,0001,dur2}, {880,0010,dur1}, {dur0}; start:
   - FETCH at c1; NOTE c2–c9 with freq_o=440, sw_o=0001, gate_o=1.
   - GAP c10–c13 with gate_o=0.
   - FETCH c14; NOTE c15–c18 with freq_o=880.
   - GAP c19–c22; FETCH c23 sees end marker.
   - done_o=1 at c24 only; busy_o=0 from c24.
3. Entry {0,0001,dur3} → gate_o=0, freq_o=0 for 12 cycles; step_o advances afterward.
4. stop_i at c5 during note 0 → c6: busy_o=0, gate_o=0, freq_o=0, step_o=0; no done_o. start_i+stop_i same cycle in IDLE → stays IDLE.
5. wr_v_i to addr 0 with data 880 while busy → wr_ready_o=0. Subsequent replay shows the original 440.
6. All 8 entries dur1, no marker:
   - Without macro: done_o after entry 7's GAP.
   - With NOTE_SEQ_LOOP_EN: step_o 7→0, done_o pulses, busy_o remains 1.

Source files
------------

// File: rtl/note_sequencer.sv
// Programmable note step sequencer driving a tone generator.
// Optional NOTE_SEQ_LOOP_EN: replay the pattern until stopped.
module note_sequencer #(
    parameter int depth_p     = 8,
    parameter int tick_div_p  = 12_000,
    parameter int gap_ticks_p = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       wr_v_i,
    output logic                       wr_ready_o,
    input  logic [$clog2(depth_p)-1:0] wr_addr_i,
    input  logic [27:0]                wr_data_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    output logic [15:0]                freq_o,
    output logic [3:0]                 sw_o,
    output logic                       gate_o,
    output logic                       busy_o,
    output logic [$clog2(depth_p)-1:0] step_o,
    output logic                       done_o
);

    localparam int aw_lp = $clog2(depth_p);
    localparam int tw_lp = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;

`ifdef NOTE_SEQ_LOOP_EN
    localparam bit loop_en_lp = 1'b1;
`else
    localparam bit loop_en_lp = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        NOTE  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t state_q, state_d, end_st;

    logic [27:0]      mem_q [depth_p];
    logic [aw_lp-1:0] step_q, step_d;
    logic [tw_lp-1:0] tick_q, tick_d;
    logic [7:0]       dur_q, dur_d;
    logic [15:0]      freq_q, freq_d;
    logic [3:0]       sw_q, sw_d;
    logic             gate_q, gate_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             end_evt;

    logic [27:0]      entry;
    logic [7:0]       e_dur;
    logic [3:0]       e_wave;
    logic [15:0]      e_freq;
    logic             tick_last;
    logic             span_done;
    logic             last_step;

    assign entry     = mem_q[step_q];
    assign e_dur     = entry[27:20];
    assign e_wave    = entry[19:16];
    assign e_freq    = entry[15:0];
    assign tick_last = (tick_q == tw_lp'(tick_div_p - 1));
    assign span_done = tick_last && (dur_q == 8'd1);
    assign last_step = (step_q == aw_lp'(depth_p - 1));
    assign end_st    = loop_en_lp ? FETCH : IDLE;

    assign wr_ready_o = rdy_q;
    assign freq_o     = freq_q;
    assign sw_o       = sw_q;
    assign gate_o     = gate_q;
    assign busy_o     = busy_q;
    assign step_o     = step_q;
    assign done_o     = done_q;

    // Pattern RAM: written only while idle, never reset
    always_ff @(posedge clk_i) begin
        if (wr_v_i && rdy_q) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            tick_q  <= '0;
            dur_q   <= '0;
            freq_q  <= '0;
            sw_q    <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            tick_q  <= tick_d;
            dur_q   <= dur_d;
            freq_q  <= freq_d;
            sw_q    <= sw_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state selection and end-of-pattern detection
    always_comb begin
        state_d = state_q;
        end_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (e_dur == 8'd0) begin
                    state_d = end_st;
                    end_evt = 1'b1;
                end else begin
                    state_d = NOTE;
                end
            end
            NOTE: begin
                if (span_done) begin
                    if (gap_ticks_p != 0) begin
                        state_d = GAP;
                    end else if (last_step) begin
                        state_d = end_st;
                        end_evt = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            GAP: begin
                if (span_done) begin
                    if (last_step) begin
                        state_d = end_st;
                        end_evt = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop_i && (state_q != IDLE)) begin
            state_d = IDLE;
            end_evt = 1'b0;
        end
    end

    // Next values of counters, step index and tone outputs
    always_comb begin
        step_d = step_q;
        tick_d = tick_q;
        dur_d  = dur_q;
        freq_d = freq_q;
        sw_d   = sw_q;
        gate_d = gate_q;
        done_d = end_evt;
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == IDLE);
        unique case (state_q)
            IDLE: begin
                step_d = '0;
            end
            FETCH: begin
                gate_d = 1'b0;
                if (state_d == NOTE) begin
                    freq_d = e_freq;
                    sw_d   = e_wave;
                    gate_d = (e_freq != 16'd0);
                    dur_d  = e_dur;
                    tick_d = '0;
                end
            end
            NOTE, GAP: begin
                tick_d = tick_last ? '0 : tick_q + 1'b1;
                if (tick_last) begin
                    dur_d = dur_q - 8'd1;
                end
                if (span_done) begin
                    gate_d = 1'b0;
                    if (state_d == GAP) begin
                        dur_d = 8'(gap_ticks_p);
                    end
                    if (state_d == FETCH) begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (end_evt) begin
            step_d = '0;
        end
        if (state_d == IDLE) begin
            step_d = '0;
            tick_d = '0;
            dur_d  = '0;
            freq_d = '0;
            sw_d   = '0;
            gate_d = 1'b0;
        end
    end

endmodule
